// File: rtl/burst_bus_scheduler.sv
// burst_bus_scheduler: N-master command scheduler in front of the PSRAM
// controller. It spaces commands by CMD_SPACING cycles, arbitrates with fixed
// priority or round-robin, streams write beats from the owning master, and
// routes returning read beats through an in-order tag FIFO.

// Per-master slot: turns the shared grant and FIFO head into this master's
// ready and read-valid bits.
module bbs_slot #(
  parameter int IDX_W = 1,
  parameter int INDEX = 0
) (
  input  logic             i_elig,
  input  logic             i_found,
  input  logic [IDX_W-1:0] i_gnt_idx,
  input  logic             i_rd_vld,
  input  logic             i_nonempty,
  input  logic [IDX_W-1:0] i_head,
  output logic             o_ready,
  output logic             o_rd_vld
);
  assign o_ready  = i_elig & i_found & (i_gnt_idx == IDX_W'(INDEX));
  assign o_rd_vld = i_rd_vld & i_nonempty & (i_head == IDX_W'(INDEX));
endmodule

module burst_bus_scheduler #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_WIDTH      = 21,
  parameter int DATA_WIDTH      = 64,
  parameter int MASK_WIDTH      = 8,
  parameter int BURST_BEATS     = 4,
  parameter int CMD_SPACING     = 14,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RR_MODE         = 0
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_MASTERS-1:0]            m_cmd_en,
  input  logic [NUM_MASTERS-1:0]            m_cmd,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wr_data,
  input  logic [NUM_MASTERS*MASK_WIDTH-1:0] m_data_mask,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic [DATA_WIDTH-1:0]             m_rd_data,
  output logic [NUM_MASTERS-1:0]            m_rd_data_valid,
  input  logic                              mem_calib,
  output logic                              mem_cmd_en,
  output logic                              mem_cmd,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wr_data,
  output logic [MASK_WIDTH-1:0]             mem_data_mask,
  input  logic [DATA_WIDTH-1:0]             mem_rd_data,
  input  logic                              mem_rd_data_valid,
  output logic                              err_orphan
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SP_W  = $clog2(CMD_SPACING + 1);
  localparam int BT_W  = $clog2(BURST_BEATS + 1);

  // per-master views of the flattened buses
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] w_wdat;
  logic [NUM_MASTERS-1:0][MASK_WIDTH-1:0] w_mask;
  assign w_addr = m_addr;
  assign w_wdat = m_wr_data;
  assign w_mask = m_data_mask;

  logic                   r_cmd_en, r_cmd;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic [MASK_WIDTH-1:0]  r_wr_mask;
  logic [BT_W-1:0]        r_wr_left;
  logic [IDX_W-1:0]       r_wr_own;
  logic [SP_W-1:0]        r_space;
  logic [IDX_W-1:0]       r_last;
  logic [MAX_OUTSTANDING-1:0][IDX_W-1:0] r_tag;
  logic [PTR_W-1:0]       r_wp, r_rp;
  logic [CNT_W-1:0]       r_cnt;
  logic [BT_W-1:0]        r_beat;
  logic                   r_err;

  logic                   w_elig, w_found, w_acc, w_push, w_pop, w_beat_ok, w_nonempty;
  logic [IDX_W-1:0]       w_gnt_idx, w_head;

  assign w_nonempty = (r_cnt != '0);
  assign w_head     = r_tag[r_rp];
  // resetn gates eligibility so calib is ignored while held in reset
  assign w_elig     = resetn & mem_calib & (r_space == '0) &
                      (r_cnt != CNT_W'(MAX_OUTSTANDING));
  assign w_acc      = w_elig & w_found;
  assign w_push     = w_acc & ~m_cmd[w_gnt_idx];
  assign w_beat_ok  = mem_rd_data_valid & w_nonempty;
  assign w_pop      = w_beat_ok & (r_beat == BT_W'(BURST_BEATS - 1));

  // pick the winning requester: lowest index, or first after the last grant
  always_comb begin
    int c;
    c         = 0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (RR_MODE != 0) c = (int'(r_last) + 1 + i) % NUM_MASTERS;
      else              c = i;
      if (!w_found && m_cmd_en[c]) begin
        w_found   = 1'b1;
        w_gnt_idx = IDX_W'(c);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_MASTERS; g++) begin : g_slot
      bbs_slot #(.IDX_W(IDX_W), .INDEX(g)) u_slot (
        .i_elig     (w_elig),
        .i_found    (w_found),
        .i_gnt_idx  (w_gnt_idx),
        .i_rd_vld   (mem_rd_data_valid),
        .i_nonempty (w_nonempty),
        .i_head     (w_head),
        .o_ready    (m_ready[g]),
        .o_rd_vld   (m_rd_data_valid[g])
      );
    end
  endgenerate

  // command strobe, type and address for the accepted request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cmd_en <= 1'b0;
      r_cmd    <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_cmd_en <= w_acc;
      if (w_acc) begin
        r_cmd  <= m_cmd[w_gnt_idx];
        r_addr <= w_addr[w_gnt_idx];
      end
    end
  end

  // spacing counter: blocks grants for CMD_SPACING-1 cycles after acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              r_space <= '0;
    else if (w_acc)           r_space <= SP_W'(CMD_SPACING - 1);
    else if (r_space != '0)   r_space <= r_space - 1'b1;
  end

  // write beat pipe: first beat on acceptance, then the owner's next beats
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_data <= '0;
      r_wr_mask <= '0;
      r_wr_left <= '0;
      r_wr_own  <= '0;
    end else if (w_acc && m_cmd[w_gnt_idx]) begin
      r_wr_data <= w_wdat[w_gnt_idx];
      r_wr_mask <= w_mask[w_gnt_idx];
      r_wr_left <= BT_W'(BURST_BEATS - 1);
      r_wr_own  <= w_gnt_idx;
    end else if (r_wr_left != '0) begin
      r_wr_data <= w_wdat[r_wr_own];
      r_wr_mask <= w_mask[r_wr_own];
      r_wr_left <= r_wr_left - 1'b1;
    end else begin
      r_wr_data <= '0;
      r_wr_mask <= '0;
    end
  end

  // round-robin pointer; starts at the top so master 0 wins first
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    r_last <= IDX_W'(NUM_MASTERS - 1);
    else if (w_acc) r_last <= w_gnt_idx;
  end

  // read tag FIFO: owner index per outstanding read, in issue order
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tag <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wp] <= w_gnt_idx;
        r_wp <= (r_wp == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= (r_rp == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // beat counter per read burst; a beat with nothing outstanding is an orphan
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_pop)          r_beat <= '0;
      else if (w_beat_ok) r_beat <= r_beat + 1'b1;
      if (mem_rd_data_valid && !w_nonempty) r_err <= 1'b1;
    end
  end

  assign m_rd_data     = mem_rd_data;
  assign mem_cmd_en    = r_cmd_en;
  assign mem_cmd       = r_cmd;
  assign mem_addr      = r_addr;
  assign mem_wr_data   = r_wr_data;
  assign mem_data_mask = r_wr_mask;
  assign err_orphan    = r_err;
endmodule
